mesi_fsm: RTL and testbench

- Per-cache MESI coherence next-state/message generator for the snooping multiprocessor.
- Each CPU instantiates one. It evaluates the addressed line's current state against either the local action (issuing mode) or the snooped bus message (snooping mode).
- It produces the line's next state, the bus message to broadcast and the memory/data-supply command.
- Outputs are registered. The CPU samples them one clock after presenting inputs.

---
 rtl/mesi_fsm.sv | 108 ++++++++++
 tb/tb_mesi_fsm.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mesi_fsm.sv
// MESI coherence next-state / bus-message / memory-command generator, one register stage.
// Optional MESI_ILLEGAL_FLAG_EN adds a registered 'illegal' output for illegal input combinations.
module mesi_fsm (
  input  logic       clock,
  input  logic       clear,
  input  logic [3:0] ctrl,
  input  logic [1:0] bus_msg,
  input  logic [1:0] cur_state,
  output logic [1:0] bus_out,
  output logic [1:0] mem_out,
  output logic [1:0] next_state
`ifdef MESI_ILLEGAL_FLAG_EN
  ,
  output logic       illegal
`endif
);

  typedef enum logic [1:0] {ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11} mesi_e;
  typedef enum logic [1:0] {BUS_NONE = 2'b00, BUS_RD = 2'b01, BUS_WR = 2'b10, BUS_INV = 2'b11} bus_e;
  typedef enum logic [1:0] {ACT_RD_MISS = 2'b00, ACT_RD_HIT = 2'b01,
                            ACT_WR_MISS = 2'b10, ACT_WR_HIT = 2'b11} act_e;
  typedef enum logic [1:0] {MEM_NONE = 2'b00, MEM_SUPPLY = 2'b01,
                            MEM_READ = 2'b10, MEM_WB = 2'b11} mem_e;

  logic       issuing, shared_in;
  logic [1:0] acao, eff_act;
  logic       cur_dirty;

  logic [1:0] bus_d, bus_q;
  logic [1:0] mem_d, mem_q;
  logic [1:0] ns_d, ns_q;
  logic       ill_d, ill_q;

  assign issuing   = ctrl[3];
  assign acao      = ctrl[2:1];
  assign shared_in = ctrl[0];
  assign cur_dirty = (cur_state == ST_M);
  // A hit on an invalid line degrades to the matching miss (clear the hit bit).
  assign eff_act   = {acao[1], acao[0] & (cur_state != ST_I)};

  always_comb begin
    ns_d  = cur_state;
    bus_d = BUS_NONE;
    mem_d = MEM_NONE;
    ill_d = 1'b0;
    if (issuing) begin
      ill_d = acao[0] & (cur_state == ST_I);
      case (eff_act)
        ACT_RD_MISS: begin
          ns_d  = shared_in ? ST_S : ST_E;
          bus_d = BUS_RD;
          mem_d = cur_dirty ? MEM_WB : MEM_READ;
        end
        ACT_RD_HIT: ns_d = cur_state;
        ACT_WR_MISS: begin
          ns_d  = ST_M;
          bus_d = BUS_WR;
          mem_d = cur_dirty ? MEM_WB : MEM_READ;
        end
        default: begin
          ns_d  = ST_M;
          bus_d = (cur_state == ST_S) ? BUS_INV : BUS_NONE;
        end
      endcase
    end else begin
      case (bus_msg)
        BUS_NONE: ns_d = cur_state;
        BUS_RD: begin
          ns_d  = (cur_state == ST_I) ? ST_I : ST_S;
          mem_d = cur_dirty ? MEM_WB : ((cur_state == ST_I) ? MEM_NONE : MEM_SUPPLY);
        end
        BUS_WR: begin
          ns_d  = ST_I;
          mem_d = cur_dirty ? MEM_WB : MEM_NONE;
        end
        default: begin
          ns_d  = ST_I;
          ill_d = (cur_state == ST_E) | (cur_state == ST_M);
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      bus_q <= BUS_NONE;
      mem_q <= MEM_NONE;
      ns_q  <= ST_I;
      ill_q <= 1'b0;
    end else begin
      bus_q <= bus_d;
      mem_q <= mem_d;
      ns_q  <= ns_d;
      ill_q <= ill_d;
    end
  end

  assign bus_out    = bus_q;
  assign mem_out    = mem_q;
  assign next_state = ns_q;
`ifdef MESI_ILLEGAL_FLAG_EN
  assign illegal    = ill_q;
`else
  logic unused_ill;
  assign unused_ill = ill_q;
`endif

endmodule

// File: tb/tb_mesi_fsm.sv
// Scoreboard bench for mesi_fsm: driver pushes model expectations, monitor pops one per clock.
module tb_mesi_fsm;
  logic       clock = 1'b0;
  logic       clear;
  logic [3:0] ctrl;
  logic [1:0] bus_msg, cur_state;
  logic [1:0] bus_out, mem_out, next_state;
`ifdef MESI_ILLEGAL_FLAG_EN
  logic       illegal;
`endif

  mesi_fsm dut (
    .clock(clock), .clear(clear), .ctrl(ctrl), .bus_msg(bus_msg), .cur_state(cur_state),
    .bus_out(bus_out), .mem_out(mem_out), .next_state(next_state)
`ifdef MESI_ILLEGAL_FLAG_EN
    , .illegal(illegal)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] ns;
    logic [1:0] bus;
    logic [1:0] mem;
    logic       ill;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: states I=0 S=1 E=2 M=3; bus none/rd/wr/inv = 0..3; mem none/supply/read/wb = 0..3.
  function automatic exp_t model(input logic [3:0] c, input logic [1:0] m, input logic [1:0] s);
    exp_t r;
    bit   write, hit, dirty, valid;
    r     = '0;
    dirty = (s == 2'd3);
    valid = (s != 2'd0);
    if (c[3]) begin
      write = c[2];
      hit   = c[1] && valid;
      r.ill = c[1] && !valid;
      if (!hit) begin
        r.bus = write ? 2'd2 : 2'd1;
        r.mem = dirty ? 2'd3 : 2'd2;
        r.ns  = write ? 2'd3 : (c[0] ? 2'd1 : 2'd2);
      end else if (write) begin
        r.ns  = 2'd3;
        r.bus = (s == 2'd1) ? 2'd3 : 2'd0;
      end else begin
        r.ns  = s;
      end
    end else begin
      r.ill = (m == 2'd3) && (s >= 2'd2);
      if (m == 2'd0) r.ns = s;
      else if (m == 2'd1) begin
        r.ns  = valid ? 2'd1 : 2'd0;
        r.mem = dirty ? 2'd3 : (valid ? 2'd1 : 2'd0);
      end else if (m == 2'd2) r.mem = dirty ? 2'd3 : 2'd0;
    end
    return r;
  endfunction

  task automatic check_zero(input string tag);
    cmp({tag, "_ns"},  next_state, 0);
    cmp({tag, "_bus"}, bus_out,    0);
    cmp({tag, "_mem"}, mem_out,    0);
`ifdef MESI_ILLEGAL_FLAG_EN
    cmp({tag, "_ill"}, illegal,    0);
`endif
  endtask

  task automatic step(input logic [3:0] c, input logic [1:0] m, input logic [1:0] s);
    @(negedge clock);
    ctrl = c; bus_msg = m; cur_state = s;
    q.push_back(clear ? exp_t'('0) : model(c, m, s));
  endtask

  // Monitor: outputs are valid one clock after the driver's negedge push.
  always @(posedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      #1;
      e = q.pop_front();
      cmp("next_state", next_state, e.ns);
      cmp("bus_out",    bus_out,    e.bus);
      cmp("mem_out",    mem_out,    e.mem);
`ifdef MESI_ILLEGAL_FLAG_EN
      cmp("illegal",    illegal,    e.ill);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; ctrl = '0; bus_msg = '0; cur_state = '0;
    #1 check_zero("reset");
    #1 clear = 1'b0;

    // directed cases
    step(4'b1000, 2'b00, 2'b00);  // rd miss, not shared -> E
    step(4'b1001, 2'b00, 2'b00);  // rd miss, shared -> S
    step(4'b1110, 2'b00, 2'b01);  // wr hit on S -> invalidate
    step(4'b1110, 2'b00, 2'b10);  // wr hit on E -> silent
    step(4'b1100, 2'b00, 2'b11);  // wr miss with dirty victim
    step(4'b0000, 2'b01, 2'b11);  // snoop rd miss on M
    step(4'b0000, 2'b01, 2'b10);  // snoop rd miss on E
    step(4'b0000, 2'b10, 2'b11);  // snoop wr miss on M
    step(4'b0000, 2'b11, 2'b01);  // invalidate on S
    step(4'b0111, 2'b11, 2'b11);  // invalidate on M (illegal)
    step(4'b1010, 2'b00, 2'b00);  // rd hit on I (illegal)
    step(4'b1000, 2'b00, 2'b01);  // next legal input

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        step(4'b1000, 2'b00, 2'b11);  // leaves outputs nonzero
        @(negedge clock);
        clear = 1'b1;
        ctrl = 4'b1100; bus_msg = 2'b00; cur_state = 2'b11;
        q.push_back('0);
        #1 check_zero("clear_async");
        @(negedge clock);
        clear = 1'b0;
        #1 check_zero("clear_release");
      end
      step(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    @(negedge clock);
    @(negedge clock);
    cmp("queue_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
